bad_pixel_replace: RTL
======================

# bad_pixel_replace

Line-local bad-pixel replacement stage directly downstream of the non-uniformity correction (NUC) stage. It consumes the corrected Y16/X16/B/K pixel stream, its per-pixel bad-pixel flag and the hs/vs framing. Each flagged pixel is replaced with a value interpolated from its horizontal neighbours on the same line. Framing is preserved with a fixed 2-cycle latency. A per-frame bad-pixel count is optional.

## Interface
- `SIGNED_SEL`, default "YES": "YES" treats pixels as two's complement; "NO" treats them as unsigned.
- `IMAGE_WIDE_LENGTH`, default 256: pixels per line.
- `IMAGE_HIGH_LENGTH`, default 192: lines per frame.
- `ADDRS_DW`, default 21: width of the bad-pixel counter.
- `DW`, default 16: pixel width.
- `i_clk`, in, 1: single clock. All logic runs on its rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_data`, in, DW: pixel from the NUC stage.
- `i_bp_type`, in, 1: 1 means `i_data` is a bad pixel.
- `i_hs`, in, 1: line valid, high for exactly IMAGE_WIDE_LENGTH contiguous cycles per line.
- `i_vs`, in, 1: frame valid.
- `i_bpr_en`, in, 1: replacement enable. Sampled only at a frame boundary.
- `o_data`, out, DW: corrected pixel.
- `o_bp_flag`, out, 1: 1 when `o_data` was replaced.
- `o_hs`, out, 1: `i_hs` delayed 2 cycles.
- `o_vs`, out, 1: `i_vs` delayed 2 cycles.
- `o_bp_cnt`, out, ADDRS_DW: number of flagged pixels in the last complete frame.

## Operation
- A pixel is valid when `{i_hs,i_vs} == 2'b11`. Invalid cycles load zero into the data and flag registers.
- Pipeline registers:
  - Centre C: pixel n and its flag.
  - Right R: pixel n+1, read directly from the input port in the cycle C is evaluated. R exists only if that cycle is valid.
  - Left L: the previous `o_data` value, which is already corrected. L exists only if the previous output cycle had `o_hs` high.
- Replacement rules, applied when the C flag is 1 and the enable shadow `en_q` is 1:
  - L exists and R exists with flag 0: output `(L+R+1)>>>1`.
    - Compute the sum at DW+1 bits, sign-extended when SIGNED_SEL="YES", zero-extended otherwise.
    - The result is always within range, so no saturation is needed.
  - L exists only (line end, or R is flagged): output L.
  - Good R only (line start): output R.
  - Neither neighbour usable: output C unchanged and set `o_bp_flag` to 0.
- When `en_q` is 0 or the C flag is 0: output C unchanged and set `o_bp_flag` to 0.
- `en_q` is loaded from `i_bpr_en` on the cycle after the `o_vs` falling edge.
- A line-position counter `hcnt` resets at `o_hs` low. It guards the L-exists check and is never used for addressing.

## Timing
- Latency is exactly 2 cycles: input pixel n at cycle t appears on `o_data` at cycle t+2. `o_hs` and `o_vs` carry the same delay.
- The last pixel of a line is evaluated in the cycle `i_hs` falls, with R absent. No extra flush cycles are needed.
- Reset values:
  - `o_data` = 0, `o_bp_flag` = 0, `o_hs` = 0, `o_vs` = 0, `o_bp_cnt` = 0.
  - `en_q` = 0: the first frame after reset passes through unchanged.
- Reset asserted mid-frame clears all pipeline state immediately. After release, the partial frame continues with no L for its first output pixel.
- A run of k consecutive flagged pixels is filled left to right from the corrected L. The run therefore takes the value of the last good pixel, averaged with R only at the final pixel of the run.

## Configuration
- Macro `BAD_PIXEL_REPLACE_STAT_EN` compiled in:
  - A counter increments on each valid input pixel with `i_bp_type` = 1. It saturates at all-ones.
  - The counter is cleared on the `i_vs` rising edge.
  - Its value is copied to `o_bp_cnt` on the `i_vs` falling edge.
- Macro absent: the counter logic is omitted and `o_bp_cnt` is tied to 0. The port is always present.

## Structure
- Package `bpr_pkg` holds:
  - `BPR_LATENCY` = 2.
  - The rounding-average function, with a signedness argument.
  - The neighbour-select encoding (AVG, LEFT, RIGHT, KEEP) as a typedef enum.
- One sub-module, `bpr_frame_stat`, holds the optional counter and latch, instantiated under the macro.

## Test plan
- Bypass: `i_bpr_en` = 0, line 100,200(bad),300 → output 100,200,300, `o_bp_flag` all 0, 2-cycle latency, `o_hs`/`o_vs` aligned.
- Interior average: enable latched, line 100,-3(bad),301 with SIGNED_SEL="YES" → 100,201,301. The same line with -4 and -6 as neighbours → -5.
- Edges: first pixel bad with next 50 → 50. Last pixel bad with previous 70 → 70. Both report `o_bp_flag` = 1.
- Run: 10,bad,bad,bad,30 → 10,10,10,20,30.
- Counter (macro on): frame containing 37 flagged pixels → `o_bp_cnt` = 37 after `i_vs` falls, holding through the next frame. With the macro off → always 0.
- Reset: assert `i_rst` mid-line → all outputs 0 asynchronously. After release, the next good pixels pass through and the first pixel has no left neighbour.

Source files
------------

// File: rtl/bpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bpr_pkg
//  Description : Shared definitions for the bad-pixel replacement stage:
//                pipeline latency, neighbour-select encoding and the
//                rounding-average helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bpr_pkg;

  // Input-to-output delay of pixel data and hs/vs framing, in clocks.
  localparam int BPR_LATENCY = 2;

  // Which value drives the output for the pixel under evaluation.
  typedef enum logic [1:0] {
    SEL_AVG   = 2'd0,  // rounded mean of left and right neighbours
    SEL_LEFT  = 2'd1,  // previous corrected output
    SEL_RIGHT = 2'd2,  // next pixel straight from the input port
    SEL_KEEP  = 2'd3   // centre pixel unchanged
  } bpr_sel_e;

  // (a + b + 1) >>> 1 on operands already extended to 32 bits by the caller
  // (sign- or zero-extended). The 33-bit sum cannot overflow, and taking
  // bits [32:1] is the arithmetic shift. For pixels of DW <= 32 bits the
  // low DW bits of the result are the exact DW-bit average.
  function automatic logic [31:0] bpr_avg(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic [32:0] w_sum;
    w_sum = {is_signed & a[31], a} + {is_signed & b[31], b} + 33'd1;
    return w_sum[32:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bad_pixel_replace_if.sv
`default_nettype none
// ============================================================================
//  Module      : bad_pixel_replace_if
//  Description : Pixel stream bundle used on both sides of the bad-pixel
//                replacement stage.
//                  data - pixel value (DW bits)
//                  bp   - bad-pixel flag (input side) / replaced flag
//                         (output side)
//                  hs   - line valid
//                  vs   - frame valid
//                Modport master drives the stream, slave receives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bad_pixel_replace_if #(
  parameter int DW = 16
);
  logic [DW-1:0] data;
  logic          bp;
  logic          hs;
  logic          vs;

  modport master (output data, bp, hs, vs);
  modport slave  (input  data, bp, hs, vs);
endinterface
`default_nettype wire

// File: rtl/bpr_frame_stat.sv
`default_nettype none
// ============================================================================
//  Module      : bpr_frame_stat
//  Description : Per-frame bad-pixel counter. Counts valid input pixels that
//                carry the bad flag, saturating at all-ones. The count is
//                restarted on the vs rising edge and published on the vs
//                falling edge, so o_bp_cnt always reflects the last complete
//                frame.
//  Ports       : i_clk, i_rst (async, active high)
//                i_hs, i_vs, i_bp_type - input stream framing and flag
//                o_bp_cnt              - flagged-pixel count of last frame
//  Revision    : 1.0 - initial release
// ============================================================================
module bpr_frame_stat
  import bpr_pkg::*;
#(
  parameter int ADDRS_DW = 21
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_bp_type,
  output logic [ADDRS_DW-1:0] o_bp_cnt
);

  logic                r_vs_d;
  logic [ADDRS_DW-1:0] r_cnt;
  logic [ADDRS_DW-1:0] r_bp_cnt;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_hit;

  assign w_vs_rise = i_vs & ~r_vs_d;
  assign w_vs_fall = ~i_vs & r_vs_d;
  assign w_hit     = i_hs & i_vs & i_bp_type;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vs_d   <= 1'b0;
      r_cnt    <= '0;
      r_bp_cnt <= '0;
    end else begin
      r_vs_d <= i_vs;
      // A flagged pixel can already be present in the vs rising cycle, so
      // the restart value includes it.
      if (w_vs_rise) begin
        r_cnt <= w_hit ? ADDRS_DW'(1) : '0;
      end else if (w_hit && (r_cnt != {ADDRS_DW{1'b1}})) begin
        r_cnt <= r_cnt + ADDRS_DW'(1);
      end
      if (w_vs_fall) begin
        r_bp_cnt <= r_cnt;
      end
    end
  end

  assign o_bp_cnt = r_bp_cnt;

endmodule
`default_nettype wire

// File: rtl/bad_pixel_replace.sv
`default_nettype none
// ============================================================================
//  Module      : bad_pixel_replace
//  Description : Line-local bad-pixel replacement. Each flagged pixel is
//                replaced from its horizontal neighbours on the same line:
//                the left neighbour is the previous corrected output, the
//                right neighbour is the next input pixel. Data, flag and
//                hs/vs framing leave exactly 2 clocks after they enter.
//                Replacement enable is shadowed once per frame, after the
//                output vs falls.
//  Config      : define BAD_PIXEL_REPLACE_STAT_EN to include the per-frame
//                bad-pixel counter; without it o_bp_cnt is tied to zero.
//  Ports       : i_clk     - clock, rising edge
//                i_rst     - asynchronous reset, active high
//                i_px      - input stream (data, bad flag, hs, vs)
//                o_px      - output stream (data, replaced flag, hs, vs)
//                i_bpr_en  - replacement enable, sampled per frame
//                o_bp_cnt  - flagged pixels in the last complete frame
//  Revision    : 1.0 - initial release
// ============================================================================
module bad_pixel_replace
  import bpr_pkg::*;
#(
  parameter     SIGNED_SEL        = "YES",
  parameter int IMAGE_WIDE_LENGTH = 256,
  parameter int IMAGE_HIGH_LENGTH = 192,
  parameter int ADDRS_DW          = 21,
  parameter int DW                = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  bad_pixel_replace_if.slave  i_px,
  bad_pixel_replace_if.master o_px,
  input  logic                i_bpr_en,
  output logic [ADDRS_DW-1:0] o_bp_cnt
);

  localparam bit c_signed = (SIGNED_SEL == "YES");
  localparam int c_hcnt_w = $clog2(IMAGE_WIDE_LENGTH + 1);

  // The averaging helper works on 32-bit operands.
  if ((DW < 2) || (DW > 32) || (IMAGE_WIDE_LENGTH < 1) ||
      (IMAGE_HIGH_LENGTH < 1) || (ADDRS_DW < 1)) begin : g_param_chk
    $error("bad_pixel_replace: unsupported parameter set");
  end

  // --------------------------------------------------------------------------
  // Centre stage
  // --------------------------------------------------------------------------
  logic          w_in_valid;
  logic [DW-1:0] r_c_data;
  logic          r_c_flag;
  logic          r_c_hs;
  logic          r_c_vs;

  assign w_in_valid = i_px.hs & i_px.vs;

  // --------------------------------------------------------------------------
  // Output stage and control
  // --------------------------------------------------------------------------
  logic [DW-1:0]       r_o_data;
  logic                r_o_flag;
  logic                r_o_hs;
  logic                r_o_vs;
  logic                r_o_vs_d;
  logic                r_en_q;
  logic [c_hcnt_w-1:0] r_hcnt;

  logic          w_l_exists;
  logic          w_r_good;
  bpr_sel_e      w_sel;
  logic [31:0]   w_l_ext;
  logic [31:0]   w_r_ext;
  logic [DW-1:0] w_avg;
  logic [DW-1:0] w_out_data;
  logic          w_out_flag;

  // r_o_data is the already-corrected left neighbour. It belongs to the
  // current line only while o_hs is high; hcnt counts the outputs of the
  // current line and is zero whenever o_hs is low.
  assign w_l_exists = r_o_hs & (r_hcnt != '0);

  // The right neighbour is the live input pixel; it is absent in the cycle
  // hs falls, which is when the last pixel of a line is evaluated.
  assign w_r_good = w_in_valid & ~i_px.bp;

  always_comb begin
    w_sel = SEL_KEEP;
    if (r_en_q && r_c_flag) begin
      if (w_l_exists && w_r_good) begin
        w_sel = SEL_AVG;
      end else if (w_l_exists) begin
        w_sel = SEL_LEFT;
      end else if (w_r_good) begin
        w_sel = SEL_RIGHT;
      end
    end
  end

  always_comb begin
    w_l_ext = 32'(r_o_data);
    w_r_ext = 32'(i_px.data);
    if (c_signed) begin
      w_l_ext = 32'($signed(r_o_data));
      w_r_ext = 32'($signed(i_px.data));
    end
  end

  assign w_avg = DW'(bpr_avg(w_l_ext, w_r_ext, c_signed));

  always_comb begin
    w_out_data = r_c_data;
    case (w_sel)
      SEL_AVG:   w_out_data = w_avg;
      SEL_LEFT:  w_out_data = r_o_data;
      SEL_RIGHT: w_out_data = i_px.data;
      default:   w_out_data = r_c_data;
    endcase
  end

  assign w_out_flag = (w_sel != SEL_KEEP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c_data <= '0;
      r_c_flag <= 1'b0;
      r_c_hs   <= 1'b0;
      r_c_vs   <= 1'b0;
      r_o_data <= '0;
      r_o_flag <= 1'b0;
      r_o_hs   <= 1'b0;
      r_o_vs   <= 1'b0;
      r_o_vs_d <= 1'b0;
      r_en_q   <= 1'b0;
      r_hcnt   <= '0;
    end else begin
      r_c_data <= w_in_valid ? i_px.data : '0;
      r_c_flag <= w_in_valid & i_px.bp;
      r_c_hs   <= i_px.hs;
      r_c_vs   <= i_px.vs;

      r_o_data <= w_out_data;
      r_o_flag <= w_out_flag;
      r_o_hs   <= r_c_hs;
      r_o_vs   <= r_c_vs;
      r_o_vs_d <= r_o_vs;

      // Tracks o_hs: cleared with it, counts while it is high.
      if (!r_c_hs) begin
        r_hcnt <= '0;
      end else if (r_hcnt != {c_hcnt_w{1'b1}}) begin
        r_hcnt <= r_hcnt + c_hcnt_w'(1);
      end

      // Enable changes only between frames: the cycle after o_vs falls.
      if (r_o_vs_d && !r_o_vs) begin
        r_en_q <= i_bpr_en;
      end
    end
  end

  assign o_px.data = r_o_data;
  assign o_px.bp   = r_o_flag;
  assign o_px.hs   = r_o_hs;
  assign o_px.vs   = r_o_vs;

  // --------------------------------------------------------------------------
  // Optional per-frame statistics
  // --------------------------------------------------------------------------
`ifdef BAD_PIXEL_REPLACE_STAT_EN
  bpr_frame_stat #(
    .ADDRS_DW (ADDRS_DW)
  ) u_frame_stat (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_hs      (i_px.hs),
    .i_vs      (i_px.vs),
    .i_bp_type (i_px.bp),
    .o_bp_cnt  (o_bp_cnt)
  );
`else
  assign o_bp_cnt = '0;
`endif

endmodule
`default_nettype wire
